// File: rtl/deb_evt_sched.sv
// Multi-channel debounce controller: shared sample-tick prescaler, per-channel stability
// counters, and a round-robin arbiter that serialises level-change events onto one port.
module deb_evt_sched #(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned CLKS_PER_SMPL = 16,
  parameter int unsigned SMPL_CNT      = 4,
  parameter int unsigned CH_W          = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] i_sig,
  output logic [N_CH-1:0] o_sig,
  output logic            o_evt_vld,
  input  logic            i_evt_rdy,
  output logic [CH_W-1:0] o_evt_ch,
  output logic            o_evt_rise,
  output logic [N_CH-1:0] o_ovf
);

  localparam int unsigned SC_W = $clog2(SMPL_CNT + 1);

  typedef enum logic {StIdle, StPresent} state_e;

  state_e                 state_q;
  logic [N_CH-1:0]        sync_q;
  logic [N_CH-1:0]        sig_s;
  logic [CLKS_PER_SMPL-1:0] pre_q;
  logic                   tck;
  logic [SC_W-1:0]        sc_q [N_CH];
  logic [N_CH-1:0]        raise;
  logic [N_CH-1:0]        pend_q;
  logic [N_CH-1:0]        pol_q;
  logic [CH_W-1:0]        ptr_q;
  logic                   gnt_any;
  logic [CH_W-1:0]        gnt_idx;
  logic                   do_load;

  function automatic logic [CH_W-1:0] wrap_idx(input logic [CH_W-1:0] base,
                                                input int unsigned off);
    int unsigned s;
    s = (32'(base) + off) % N_CH;
    return CH_W'(s);
  endfunction

  // Two-flop synchroniser and free-running sample prescaler.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      sig_s  <= '0;
      pre_q  <= '0;
    end else begin
      sync_q <= i_sig;
      sig_s  <= sync_q;
      pre_q  <= pre_q + 1'b1;
    end
  end

  assign tck = &pre_q;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      raise[i] = tck && (sig_s[i] != o_sig[i]) && ((32'(sc_q[i]) + 1) == SMPL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_sig <= '0;
      for (int i = 0; i < N_CH; i++) begin
        sc_q[i] <= '0;
      end
    end else if (tck) begin
      for (int i = 0; i < N_CH; i++) begin
        if (sig_s[i] == o_sig[i]) begin
          sc_q[i] <= '0;
        end else if (raise[i]) begin
          o_sig[i] <= ~o_sig[i];
          sc_q[i]  <= '0;
        end else begin
          sc_q[i] <= sc_q[i] + 1'b1;
        end
      end
    end
  end

  // Round-robin search from ptr+1; descending loop so the nearest set channel wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = N_CH; k >= 1; k--) begin
      if (pend_q[wrap_idx(ptr_q, k)]) begin
        gnt_any = 1'b1;
        gnt_idx = wrap_idx(ptr_q, k);
      end
    end
  end

  assign do_load = gnt_any && ((state_q == StIdle) || i_evt_rdy);

  // A raise on a channel being granted this cycle is a fresh event, not an overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      pol_q  <= '0;
      o_ovf  <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (raise[i]) begin
          pend_q[i] <= 1'b1;
          pol_q[i]  <= ~o_sig[i];
          if (pend_q[i] && !(do_load && (gnt_idx == CH_W'(i)))) begin
            o_ovf[i] <= 1'b1;
          end
        end else if (do_load && (gnt_idx == CH_W'(i))) begin
          pend_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= CH_W'(N_CH - 1);
      o_evt_ch   <= '0;
      o_evt_rise <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (gnt_any) begin
            o_evt_ch   <= gnt_idx;
            o_evt_rise <= pol_q[gnt_idx];
            ptr_q      <= gnt_idx;
            state_q    <= StPresent;
          end
        end
        StPresent: begin
          if (i_evt_rdy) begin
            if (gnt_any) begin
              o_evt_ch   <= gnt_idx;
              o_evt_rise <= pol_q[gnt_idx];
              ptr_q      <= gnt_idx;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_evt_vld = (state_q == StPresent);

endmodule

// File: tb/tb_deb_evt_sched.sv
// Directed bench for deb_evt_sched: scoreboard of expected events plus direct timing checks.
module tb_deb_evt_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] i_sig = '0;
  logic [3:0] o_sig;
  logic       o_evt_vld;
  logic       i_evt_rdy = 1'b1;
  logic [1:0] o_evt_ch;
  logic       o_evt_rise;
  logic [3:0] o_ovf;

  typedef struct packed {
    logic [1:0] ch;
    logic       rise;
  } evt_t;

  evt_t sb_q[$];
  evt_t mon_e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  deb_evt_sched #(
    .N_CH         (4),
    .CLKS_PER_SMPL(2),
    .SMPL_CNT     (3),
    .CH_W         (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_sig     (i_sig),
    .o_sig     (o_sig),
    .o_evt_vld (o_evt_vld),
    .i_evt_rdy (i_evt_rdy),
    .o_evt_ch  (o_evt_ch),
    .o_evt_rise(o_evt_rise),
    .o_ovf     (o_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns 1ns after the next edge on which the prescaler ticks.
  task automatic tick_edge();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 16 && !seen; k++) begin
      @(negedge clk);
      seen = dut.tck;
    end
    if (!seen) chk("tck_seen", 32'(seen), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] ch, input logic rise);
    evt_t e;
    e.ch   = ch;
    e.rise = rise;
    sb_q.push_back(e);
  endtask

  task automatic chk_out(input string tag, input logic vld, input logic [1:0] ch,
                         input logic rise);
    chk({tag, "_vld"}, 32'(o_evt_vld), 32'(vld));
    chk({tag, "_ch"}, 32'(o_evt_ch), 32'(ch));
    chk({tag, "_rise"}, 32'(o_evt_rise), 32'(rise));
  endtask

  // Scoreboard: every accepted event must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && o_evt_vld && i_evt_rdy) begin
      chk("evt_expected", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        chk("evt_ch", 32'(o_evt_ch), 32'(mon_e.ch));
        chk("evt_rise", 32'(o_evt_rise), 32'(mon_e.rise));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_o_sig", 32'(o_sig), 0);
    chk_out("rst", 1'b0, 2'd0, 1'b0);
    chk("rst_ovf", 32'(o_ovf), 0);

    // Prescaler: first tick 3 cycles after reset release, then every 4.
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("tck_period", 32'(dut.tck), 32'(k % 4 == 3));
    end

    // Clean press on ch0.
    tick_edge();
    i_sig[0] = 1'b1;
    push(2'd0, 1'b1);
    tick_edge();
    tick_edge();
    chk("press_early", 32'(o_sig[0]), 0);
    tick_edge();
    chk("press_o_sig", 32'(o_sig[0]), 1);
    cyc(1);
    chk_out("press_evt", 1'b1, 2'd0, 1'b1);
    cyc(1);
    chk("press_vld_drop", 32'(o_evt_vld), 0);
    chk("press_ovf", 32'(o_ovf), 0);

    // Glitch of 2 ticks rejected, 3 ticks accepted.
    tick_edge();
    i_sig[1] = 1'b1;
    tick_edge();
    tick_edge();
    i_sig[1] = 1'b0;
    repeat (4) tick_edge();
    chk("glitch_o_sig", 32'(o_sig[1]), 0);
    tick_edge();
    i_sig[1] = 1'b1;
    push(2'd1, 1'b1);
    repeat (3) tick_edge();
    chk("glitch3_o_sig", 32'(o_sig[1]), 1);
    cyc(3);

    // Fresh reset so the arbitration pointer starts at ch3.
    rst   = 1'b1;
    i_sig = '0;
    cyc(2);
    rst = 1'b0;

    tick_edge();
    i_sig[2:1] = 2'b11;
    push(2'd1, 1'b1);
    push(2'd2, 1'b1);
    repeat (3) tick_edge();
    chk("arb_o_sig", 32'(o_sig), 32'h6);
    cyc(1);
    chk_out("arb1_a", 1'b1, 2'd1, 1'b1);
    cyc(1);
    chk_out("arb1_b", 1'b1, 2'd2, 1'b1);
    cyc(1);
    chk("arb1_idle", 32'(o_evt_vld), 0);

    tick_edge();
    i_sig[2:1] = 2'b00;
    push(2'd1, 1'b0);
    push(2'd2, 1'b0);
    repeat (3) tick_edge();
    cyc(1);
    chk_out("arb2_a", 1'b1, 2'd1, 1'b0);
    cyc(1);
    chk_out("arb2_b", 1'b1, 2'd2, 1'b0);
    cyc(1);
    chk("arb2_idle", 32'(o_evt_vld), 0);

    // Backpressure: release then press on ch3 while its first event is held.
    i_evt_rdy = 1'b0;
    tick_edge();
    i_sig[3] = 1'b1;
    push(2'd3, 1'b1);
    repeat (3) tick_edge();
    cyc(1);
    chk_out("bp_hold0", 1'b1, 2'd3, 1'b1);
    tick_edge();
    i_sig[3] = 1'b0;
    repeat (3) tick_edge();
    chk("bp_rel_o_sig", 32'(o_sig[3]), 0);
    chk("bp_rel_ovf", 32'(o_ovf), 0);
    chk_out("bp_hold1", 1'b1, 2'd3, 1'b1);
    tick_edge();
    i_sig[3] = 1'b1;
    push(2'd3, 1'b1);
    repeat (3) tick_edge();
    cyc(1);
    chk("bp_ovf", 32'(o_ovf), 32'h8);
    chk_out("bp_hold2", 1'b1, 2'd3, 1'b1);
    i_evt_rdy = 1'b1;
    cyc(1);
    chk_out("bp_merged", 1'b1, 2'd3, 1'b1);
    cyc(1);
    chk("bp_idle", 32'(o_evt_vld), 0);
    chk("bp_ovf_sticky", 32'(o_ovf), 32'h8);

    // Reset with an event presented and ch2 still pending.
    i_evt_rdy = 1'b0;
    tick_edge();
    i_sig[2:1] = 2'b11;
    repeat (3) tick_edge();
    cyc(1);
    chk_out("mid_pre", 1'b1, 2'd1, 1'b1);
    chk("mid_pend2", 32'(dut.pend_q[2]), 1);
    rst   = 1'b1;
    i_sig = '0;
    cyc(1);
    chk("mid_o_sig", 32'(o_sig), 0);
    chk_out("mid_rst", 1'b0, 2'd0, 1'b0);
    chk("mid_ovf", 32'(o_ovf), 0);
    rst       = 1'b0;
    i_evt_rdy = 1'b1;
    repeat (5) tick_edge();
    chk("mid_quiet", 32'(o_evt_vld), 0);
    tick_edge();
    i_sig = 4'b1001;
    push(2'd0, 1'b1);
    push(2'd3, 1'b1);
    repeat (3) tick_edge();
    cyc(1);
    chk_out("mid_prio_a", 1'b1, 2'd0, 1'b1);
    cyc(1);
    chk_out("mid_prio_b", 1'b1, 2'd3, 1'b1);
    cyc(2);
    chk("sb_drained", 32'(sb_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/deb_evt_sched.md
Name: deb_evt_sched

Overview:
- Multi-channel debounce controller: one shared sample-tick prescaler times N_CH per-channel stability counters.
- Each channel has a clean level output. Every debounced level change becomes a press/release event.
- Pending events from all channels are served by a round-robin arbiter onto a single valid/ready event port.
- Sits between raw board inputs (buttons, switches) and the control FSMs that consume input events.

Parameters:
- N_CH, 4: number of input channels (>=2).
- CLKS_PER_SMPL, 16: prescaler width; one sample tick every 2^CLKS_PER_SMPL clocks.
- SMPL_CNT, 4: consecutive disagreeing ticks needed to change a debounced level (>=1).
- CH_W, 2: event channel index width, must be >= ceil(log2(N_CH)).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- i_sig  in  N_CH  raw asynchronous inputs
- o_sig  out  N_CH  debounced levels
- o_evt_vld  out  1  event valid
- i_evt_rdy  in  1  consumer ready
- o_evt_ch  out  CH_W  channel index of presented event
- o_evt_rise  out  1  1 = rising (press), 0 = falling (release)
- o_ovf  out  N_CH  sticky per-channel overflow (event lost/merged)

Behaviour:
- Reset: all state clears on a clk edge with rst=1. Sync flops, prescaler, stability counters, pending bits, o_sig, o_evt_vld, o_evt_ch, o_evt_rise and o_ovf all go to 0. Round-robin pointer goes to N_CH-1, so ch0 has first priority. rst mid-operation discards in-flight and pending events.
- Synchroniser: 2 flops per channel. sig_s[i] is i_sig[i] delayed 2 clocks.
- Prescaler: free-running CLKS_PER_SMPL-bit counter, wraps. tck=1 for exactly one cycle when the counter is all ones, i.e. every 2^CLKS_PER_SMPL cycles. The first tck occurs 2^CLKS_PER_SMPL-1 cycles after rst deasserts.
- Per-channel stability counter sc[i], width ceil(log2(SMPL_CNT+1)). It only acts on tck:
  - sig_s==o_sig: sc<=0.
  - otherwise, if sc+1==SMPL_CNT: o_sig toggles, sc<=0, event raised.
  - otherwise: sc<=sc+1.
  - The filter is symmetric: both press and release need SMPL_CNT consecutive disagreeing ticks. Between ticks, sc and o_sig hold.
- Event raise: sets pend[i] and pol[i] (pol = new o_sig value) on the same edge that o_sig toggles.
  - If pend[i] is already set and not granted that cycle: pol[i] is overwritten with the newest value and o_ovf[i]<=1 (sticky until rst).
  - If the raise coincides with the grant of the same channel: the old event is granted, the new one sets pend[i] with no overflow.
- Arbiter/output FSM, two states:
  - IDLE (o_evt_vld=0): if any pend set, grant the first set channel searching ptr+1, ptr+2, ... mod N_CH. Load o_evt_ch/o_evt_rise, clear that pend, set ptr to the granted channel, go to PRESENT.
  - PRESENT (o_evt_vld=1): o_evt_ch and o_evt_rise stay stable while i_evt_rdy=0. On vld&rdy: if another pend is set, load the next grant in the same cycle (back-to-back, no bubble) and stay in PRESENT; else go to IDLE.
- Latency: o_sig toggles at the tck edge. o_evt_vld asserts at the next edge when the FSM is IDLE.
- No event is ever dropped except via the overflow merge above.

Test Plan:
- Params for all tests: N_CH=4, CLKS_PER_SMPL=2 (tck every 4 clocks), SMPL_CNT=3.
- Clean press: i_sig[0] 0->1 and held, i_evt_rdy=1.
  - o_sig[0] rises on the 3rd tck after sig_s[0] goes high.
  - Next cycle: o_evt_vld=1, o_evt_ch=0, o_evt_rise=1 for one cycle.
  - o_ovf stays 0.
- Glitch rejection: i_sig[1] high for exactly 2 ticks, then low.
  - o_sig[1] stays 0, no event.
  - Repeat with high for 3 ticks: event ch1 rise=1.
- Arbitration: ch1 and ch2 toggle on the same tck, rdy=1.
  - Events ch1 then ch2 on consecutive cycles.
  - Then ch1 and ch2 toggle together again: ch1 first (search order ch3, ch0, ch1), then ch2.
- Backpressure/overflow: rdy=0 while o_evt_vld holds ch3 rise=1.
  - ch3 completes a release (pend set, no overflow), then a press (overflow).
  - o_evt_ch/o_evt_rise stay stable throughout. o_ovf[3]=1.
  - After rdy=1: first the held ch3 rise=1 event, then one ch3 event with rise=1 (the merged event carries the newest polarity).
- Reset mid-operation: assert rst with o_evt_vld=1 and pend on ch2.
  - Next cycle all outputs are 0.
  - No event appears after release until fresh stable input, with ch0 priority restored.
- Prescaler period: with all inputs static, tck pulses exactly every 4 cycles.
  - The first tck is 3 cycles after rst deasserts, confirmed by internal probe.
